booth_job_sequencer: RTL and testbench
======================================

Name: booth_job_sequencer

Overview:
- Feeds the 4-bit radix-4 Booth multiplier controller and collects its products.
- Upstream side: buffers operand pairs from a valid/ready producer in a small FIFO.
- Multiplier side: issues each job as a one-cycle start pulse with stable operands, then waits for done.
- Downstream side: presents each product, with a job tag, on a single-entry valid/ready output register.

Parameters:
- DEPTH, 4, operand FIFO entries; power of 2, at least 2.
- OP_W, 4, operand width; product width is 2*OP_W.
- TAG_W, 4, job tag width.
- TIMEOUT, 16, watchdog limit in WAIT cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept; equals !full
- in_a  in  OP_W  multiplicand, signed
- in_b  in  OP_W  multiplier, signed
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_a  out  OP_W  operand A to the multiplier, registered
- mul_b  out  OP_W  operand B to the multiplier, registered
- mul_result  in  2*OP_W  product from the multiplier
- mul_done  in  1  multiplier done
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_result  out  2*OP_W  captured product
- out_tag  out  TAG_W  sequence number of the job
- out_err  out  1  result produced by watchdog expiry
- busy  out  1  state is not IDLE, or FIFO not empty

Behaviour:
- Reset (rst=0, async): FIFO emptied, pointers and count 0; state IDLE.
  - All outputs 0 except in_ready=1; tag counter 0.
  - Reset mid-job abandons the job; any mul_done arriving afterwards is ignored.
- FIFO:
  - Push on in_valid && in_ready.
  - Pop occurs on the ISSUE cycle.
  - Push and pop in the same cycle: count unchanged. This is legal when full, but in_ready=0 when full, so no push happens then.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if count>0 and (!out_valid or out_ready), go to ISSUE at the next edge. Load mul_a/mul_b from the FIFO head and pop the FIFO.
  - ISSUE (1 cycle): mul_start=1; go to WAIT.
  - WAIT: mul_start=0; mul_a/mul_b held stable.
    - On mul_done=1: out_result<=mul_result, out_tag<=tag, out_err<=0, out_valid<=1, tag<=tag+1 (wraps to 0), go to IDLE.
- mul_done is honoured only in WAIT; it is ignored in IDLE and ISSUE.
- Output register:
  - out_valid stays set until a cycle with out_ready=1.
  - out_result, out_tag and out_err are stable while out_valid=1 and out_ready=0.
  - Capture and drain in the same cycle are impossible; the next capture is at least 3 cycles away.
- Latency:
  - Pair pushed at edge E0 with FIFO empty, state IDLE and output free: mul_start high from E1 to E2.
  - out_valid rises at the edge following the first WAIT cycle with mul_done=1.
- The product is passed through unmodified; no sign or width adjustment.

Optional Feature:
- Macro: BOOTH_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without mul_done.
  - When it reaches TIMEOUT: out_result<=0, out_err<=1, out_valid<=1, tag increments, go to IDLE.
  - mul_done and expiry in the same cycle: mul_done wins.
- Not defined: no counter; WAIT lasts indefinitely; out_err is tied to 0.

Test Plan:
1. Reset, then push a=4'b1101 (-3), b=4'b1011 (-5); multiplier model returns the signed product 3 cycles after start.
   -> mul_start pulses one cycle at E1; out_result=8'h0F, out_tag=0, out_err=0; busy drops after the output drains.
2. Hold out_ready=0 and push 6 pairs (DEPTH=4), e.g. (2,3),(−1,7),(4,4),(−8,−8),(1,1),(0,5).
   -> in_ready falls once the FIFO holds 4 while a job is pending.
   -> No second mul_start until out_ready=1.
   -> Results drain in order: 8'h06, 8'hF9, 8'h10, 8'h40, 8'h01, 8'h00 with tags 0..5.
3. Drive mul_done high during IDLE and during ISSUE.
   -> Ignored: no capture; out_valid remains 0 until the real done in WAIT.
4. Assert rst=0 in the middle of WAIT, release, then pulse mul_done.
   -> All outputs at reset values; the stale done is ignored; the tag restarts at 0 on the next job.
5. Run 17 jobs back to back. -> out_tag runs 0..15 and wraps to 0 on the 17th.
6. With BOOTH_SEQ_TIMEOUT_EN defined, TIMEOUT=16, and the model never asserting done.
   -> Exactly 16 WAIT cycles, then out_valid=1, out_result=8'h00, out_err=1; the next queued job issues normally.

Source files
------------

// File: rtl/booth_job_sequencer_if.sv
// Handshake/bus bundle between booth_job_sequencer, its operand producer,
// the Booth multiplier controller and the result consumer.
interface booth_job_sequencer_if #(
    parameter int unsigned OP_W  = 4,
    parameter int unsigned TAG_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OP_W-1:0]       in_a;
    logic [OP_W-1:0]       in_b;
    logic                  mul_start;
    logic [OP_W-1:0]       mul_a;
    logic [OP_W-1:0]       mul_b;
    logic [2*OP_W-1:0]     mul_result;
    logic                  mul_done;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*OP_W-1:0]     out_result;
    logic [TAG_W-1:0]      out_tag;
    logic                  out_err;

    // Environment side: producer, multiplier and consumer
    modport master (
        output in_valid, in_a, in_b, mul_result, mul_done, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_tag, out_err
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_a, in_b, mul_result, mul_done, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_result, out_tag, out_err
    );
endinterface

// File: rtl/booth_job_sequencer.sv
// Queues operand pairs, issues them to the Booth multiplier and returns tagged products.
// Optional watchdog on the multiplier wait: define BOOTH_SEQ_TIMEOUT_EN.
module booth_job_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    booth_job_sequencer_if.slave   bus,
    output logic                   busy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RES_W = 2 * OP_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("booth_job_sequencer: DEPTH must be a power of 2 >= 2, TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state_q, state_nxt;
    logic [OP_W-1:0]     fifo_a [DEPTH];
    logic [OP_W-1:0]     fifo_b [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                mul_start_q;
    logic [OP_W-1:0]     mul_a_q, mul_b_q;
    logic                out_valid_q;
    logic [RES_W-1:0]    out_result_q;
    logic [TAG_W-1:0]    out_tag_q, tag_q;
    logic                out_err_q;
    logic                full_c, push_c, issue_c, capture_c, expire_c;

    assign full_c = (count_q == CNT_W'(DEPTH));
    assign push_c = bus.in_valid && !full_c;

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt = state_q;
        issue_c   = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && (!out_valid_q || bus.out_ready)) begin
                    issue_c   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (bus.mul_done || expire_c) begin
                    capture_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_nxt;
    end

    // Operand storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_a[wr_ptr_q] <= bus.in_a;
            fifo_b[wr_ptr_q] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            tag_q        <= '0;
        end else begin
            if (push_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (issue_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_q + CNT_W'(push_c) - CNT_W'(issue_c);
            mul_start_q <= issue_c;
            if (issue_c) begin
                mul_a_q <= fifo_a[rd_ptr_q];
                mul_b_q <= fifo_b[rd_ptr_q];
            end
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            // A capture only happens in WAIT, where the output slot is already free
            if (capture_c) begin
                out_valid_q  <= 1'b1;
                out_result_q <= bus.mul_done ? bus.mul_result : '0;
                out_tag_q    <= tag_q;
                tag_q        <= tag_q + TAG_W'(1);
            end
        end
    end

`ifdef BOOTH_SEQ_TIMEOUT_EN
    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    logic [WCNT_W-1:0] wait_cnt_q;

    // mul_done has priority over expiry in the same cycle
    assign expire_c = (state_q == WAIT) && !bus.mul_done
                      && (wait_cnt_q == WCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            if (state_q == ISSUE)
                wait_cnt_q <= '0;
            else if (state_q == WAIT && !bus.mul_done)
                wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
            if (capture_c) out_err_q <= !bus.mul_done;
        end
    end
`else
    assign expire_c  = 1'b0;
    assign out_err_q = 1'b0;
`endif

    assign bus.in_ready   = !full_c;
    assign bus.mul_start  = mul_start_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_err    = out_err_q;
    assign busy           = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_booth_job_sequencer.sv
// Directed bench for booth_job_sequencer with a 3-cycle behavioural Booth multiplier.
// Timeout scenario runs only when BOOTH_SEQ_TIMEOUT_EN is defined.
module tb_booth_job_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    booth_job_sequencer_if #(.OP_W(4), .TAG_W(4)) bus ();

    booth_job_sequencer #(.DEPTH(4), .OP_W(4), .TAG_W(4), .TIMEOUT(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int checks    = 0;
    int errors    = 0;
    int start_cnt = 0;

    // Multiplier model: done one cycle, three cycles after sampling start
    logic       model_en = 1'b1;
    logic       m_done   = 1'b0;
    logic [7:0] m_res    = '0;
    logic [7:0] m_prod   = '0;
    int         m_cnt    = 0;
    logic       f_done   = 1'b0;
    logic [7:0] f_res    = '0;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_res  <= m_prod;
            end
        end
        if (bus.mul_start && model_en) begin
            m_cnt  <= 3;
            m_prod <= 8'($signed({{4{bus.mul_a[3]}}, bus.mul_a}) * $signed({{4{bus.mul_b[3]}}, bus.mul_b}));
        end
    end

    always @(posedge clk) if (bus.mul_start === 1'b1) start_cnt++;

    assign bus.mul_done   = m_done | f_done;
    assign bus.mul_result = f_done ? f_res : m_res;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        f_done   = 1'b0;
        model_en = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (bus.in_ready) ok = 1;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL push_timeout: in_ready never seen for a=%h b=%h", a, b); end
    endtask

    task automatic wait_out();
        for (int i = 0; i < 100 && !bus.out_valid; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL out_valid_timeout: got %b expected 1", bus.out_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        repeat (2) tick();
        checks++; if (bus.in_ready !== 1'b1)    begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.mul_start !== 1'b0)   begin errors++; $display("FAIL rst_mul_start: got %b expected 0", bus.mul_start); end
        checks++; if (bus.mul_a !== 4'h0)       begin errors++; $display("FAIL rst_mul_a: got %h expected 0", bus.mul_a); end
        checks++; if (bus.out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_result !== 8'h00) begin errors++; $display("FAIL rst_out_result: got %h expected 00", bus.out_result); end
        checks++; if (bus.out_tag !== 4'h0)     begin errors++; $display("FAIL rst_out_tag: got %h expected 0", bus.out_tag); end
        checks++; if (bus.out_err !== 1'b0)     begin errors++; $display("FAIL rst_out_err: got %b expected 0", bus.out_err); end
        checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_job();
        int s0;
        do_reset();
        s0 = start_cnt;
        push(4'hD, 4'hB);
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL t1_start_early: got %b expected 0", bus.mul_start); end
        tick();
        checks++; if (bus.mul_start !== 1'b1) begin errors++; $display("FAIL t1_start_e1: got %b expected 1", bus.mul_start); end
        checks++; if ({bus.mul_a, bus.mul_b} !== 8'hDB) begin errors++; $display("FAIL t1_operands: got %h expected DB", {bus.mul_a, bus.mul_b}); end
        tick();
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL t1_start_e2: got %b expected 0", bus.mul_start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_wait: got %b expected 1", busy); end
        wait_out();
        checks++; if (bus.out_result !== 8'h0F) begin errors++; $display("FAIL t1_result: got %h expected 0F", bus.out_result); end
        checks++; if (bus.out_tag !== 4'h0)     begin errors++; $display("FAIL t1_tag: got %h expected 0", bus.out_tag); end
        checks++; if (bus.out_err !== 1'b0)     begin errors++; $display("FAIL t1_err: got %b expected 0", bus.out_err); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t1_drain: got %b expected 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_idle: got %b expected 0", busy); end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL t1_start_count: got %0d expected 1", start_cnt - s0); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_r [6] = '{8'h06, 8'hF9, 8'h10, 8'h40, 8'h01, 8'h00};
        int s0;
        int got = 0;
        do_reset();
        s0 = start_cnt;
        push(4'h2, 4'h3);
        push(4'hF, 4'h7);
        push(4'h4, 4'h4);
        push(4'h8, 4'h8);
        push(4'h1, 4'h1);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL t2_full: in_ready got %b expected 0", bus.in_ready); end
        repeat (12) tick();
        checks++; if (bus.out_valid !== 1'b1)   begin errors++; $display("FAIL t2_held_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_result !== 8'h06) begin errors++; $display("FAIL t2_held_result: got %h expected 06", bus.out_result); end
        checks++; if (start_cnt - s0 !== 1)     begin errors++; $display("FAIL t2_stalled_start: got %0d expected 1", start_cnt - s0); end
        checks++; if (bus.in_ready !== 1'b0)    begin errors++; $display("FAIL t2_still_full: got %b expected 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        fork
            push(4'h0, 4'h5);
            begin
                for (int c = 0; c < 300 && got < 6; c++) begin
                    if (bus.out_valid) begin
                        checks++; if (bus.out_result !== exp_r[got]) begin errors++; $display("FAIL t2_result%0d: got %h expected %h", got, bus.out_result, exp_r[got]); end
                        checks++; if (bus.out_tag !== 4'(got)) begin errors++; $display("FAIL t2_tag%0d: got %h expected %h", got, bus.out_tag, 4'(got)); end
                    got++;
                    end
                    tick();
                end
            end
        join
        checks++; if (got !== 6) begin errors++; $display("FAIL t2_drain_count: got %0d expected 6", got); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_early_done();
        do_reset();
        model_en = 1'b0;
        f_res  = 8'hAA;
        f_done = 1'b1;
        repeat (2) tick();
        f_done = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t3_idle_done: out_valid got %b expected 0", bus.out_valid); end
        push(4'h3, 4'h2);
        f_done = 1'b1;
        tick();
        checks++; if (bus.mul_start !== 1'b1) begin errors++; $display("FAIL t3_issue: mul_start got %b expected 1", bus.mul_start); end
        tick();
        f_done = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t3_issue_done: out_valid got %b expected 0", bus.out_valid); end
        repeat (3) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t3_wait_idle: out_valid got %b expected 0", bus.out_valid); end
        f_res  = 8'h06;
        f_done = 1'b1;
        tick();
        f_done = 1'b0;
        checks++; if (bus.out_valid !== 1'b1)   begin errors++; $display("FAIL t3_real_done: out_valid got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_result !== 8'h06) begin errors++; $display("FAIL t3_result: got %h expected 06", bus.out_result); end
        checks++; if (bus.out_tag !== 4'h0)     begin errors++; $display("FAIL t3_tag: got %h expected 0", bus.out_tag); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        do_reset();
        push(4'h2, 4'h2);
        repeat (2) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_wait: got %b expected 1", busy); end
        rst = 1'b0;
        #1;
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL t4_mul_start: got %b expected 0", bus.mul_start); end
        checks++; if ({bus.mul_a, bus.mul_b} !== 8'h00) begin errors++; $display("FAIL t4_operands: got %h expected 00", {bus.mul_a, bus.mul_b}); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL t4_busy: got %b expected 0", busy); end
        checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL t4_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        rst = 1'b1;
        f_res  = 8'h55;
        f_done = 1'b1;
        tick();
        f_done = 1'b0;
        repeat (5) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t4_stale_done: out_valid got %b expected 0", bus.out_valid); end
        push(4'h1, 4'h3);
        wait_out();
        checks++; if (bus.out_result !== 8'h03) begin errors++; $display("FAIL t4_result: got %h expected 03", bus.out_result); end
        checks++; if (bus.out_tag !== 4'h0)     begin errors++; $display("FAIL t4_tag_restart: got %h expected 0", bus.out_tag); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_tag;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            exp_tag = (i == 16) ? 4'h0 : 4'(i);
            push(4'h3, 4'h2);
            wait_out();
            checks++; if (bus.out_tag !== exp_tag)  begin errors++; $display("FAIL t5_tag%0d: got %h expected %h", i, bus.out_tag, exp_tag); end
            checks++; if (bus.out_result !== 8'h06) begin errors++; $display("FAIL t5_result%0d: got %h expected 06", i, bus.out_result); end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

`ifdef BOOTH_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        do_reset();
        model_en = 1'b0;
        push(4'h2, 4'h3);
        push(4'h1, 4'h1);
        for (int i = 0; i < 10 && !bus.mul_start; i++) tick();
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n !== 17) begin errors++; $display("FAIL t6_wait_len: edges after start got %0d expected 17", n); end
        checks++; if (bus.out_result !== 8'h00) begin errors++; $display("FAIL t6_result: got %h expected 00", bus.out_result); end
        checks++; if (bus.out_err !== 1'b1)     begin errors++; $display("FAIL t6_err: got %b expected 1", bus.out_err); end
        checks++; if (bus.out_tag !== 4'h0)     begin errors++; $display("FAIL t6_tag: got %h expected 0", bus.out_tag); end
        model_en = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        wait_out();
        checks++; if (bus.out_result !== 8'h01) begin errors++; $display("FAIL t6_next_result: got %h expected 01", bus.out_result); end
        checks++; if (bus.out_err !== 1'b0)     begin errors++; $display("FAIL t6_next_err: got %b expected 0", bus.out_err); end
        checks++; if (bus.out_tag !== 4'h1)     begin errors++; $display("FAIL t6_next_tag: got %h expected 1", bus.out_tag); end
        tick();
        bus.out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_backpressure();
        test_early_done();
        test_reset_mid_job();
        test_back_to_back();
`ifdef BOOTH_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
